// File: rtl/xprog_loader_pkg.sv
// Shared types and constants for the serial program loader.
// Word width, address width, FSM encoding and frame limits.
package xprog_loader_pkg;

    localparam int INSTR_W         = 32;
    localparam int PROG_ROM_ADDR_W = 8;
    localparam int LEN_W           = 16;
    localparam int MAX_WORDS       = 1 << PROG_ROM_ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic logic takes_byte(state_t s);
        return s inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM};
    endfunction

    function automatic logic in_session(state_t s);
        return s inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_WRITE, ST_CSUM};
    endfunction

endpackage

// File: rtl/xprog_loader_word_asm.sv
// Byte-to-word assembler: little-endian shift register with a
// byte index; word_full flags the load that completes a word.
module xprog_word_asm #(
    parameter int BPW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [7:0]       byte_in,
    output logic [8*BPW-1:0] word,
    output logic             word_full
);

    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [8*BPW-1:0] word_q, word_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [8*BPW+7:0] shifted;

    assign word_full = load && (idx_q == IDX_W'(BPW - 1));
    // New bytes enter at the top, so byte 0 ends up in bits [7:0].
    assign shifted   = {byte_in, word_q};
    assign word      = word_q;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clr) begin
            word_d = '0;
            idx_d  = '0;
        end else if (load) begin
            word_d = shifted[8*BPW+7:8];
            idx_d  = word_full ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/xprog_loader.sv
// Streams a length-prefixed, XOR-checked image into program RAM
// and holds the CPU in reset until a valid image has landed.
module xprog_loader
    import xprog_loader_pkg::*;
#(
    parameter int BPW = INSTR_W / 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       byte_valid,
    input  logic [7:0]                 byte_data,
    output logic                       byte_ready,
    output logic                       mem_we,
    output logic [PROG_ROM_ADDR_W-1:0] mem_addr,
    output logic [8*BPW-1:0]           mem_wdata,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       cpu_rst
);

    state_t                     state_q, state_d;
    logic [7:0]                 len_lo_q, len_lo_d;
    logic [LEN_W-1:0]           left_q, left_d;
    logic [7:0]                 csum_q, csum_d;
    logic [PROG_ROM_ADDR_W-1:0] addr_q, addr_d;
    logic                       byte_ready_q, byte_ready_d;
    logic                       mem_we_q, mem_we_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       cpu_rst_q, cpu_rst_d;

    logic             accept;
    logic             asm_clr;
    logic             asm_load;
    logic             word_full;
    logic [LEN_W-1:0] len_n;

    assign accept   = byte_valid && byte_ready_q;
    assign asm_load = accept && (state_q == ST_DATA);
    assign len_n    = {byte_data, len_lo_q};

    xprog_word_asm #(.BPW(BPW)) u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (asm_clr),
        .load      (asm_load),
        .byte_in   (byte_data),
        .word      (mem_wdata),
        .word_full (word_full)
    );

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        left_d   = left_q;
        csum_d   = csum_q;
        addr_d   = addr_q;
        asm_clr  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN_LO;
                    csum_d  = '0;
                    addr_d  = '0;
                    left_d  = '0;
                    asm_clr = 1'b1;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_lo_d = byte_data;
                    csum_d   = csum_q ^ byte_data;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    csum_d = csum_q ^ byte_data;
                    left_d = len_n;
                    if (len_n == '0)
                        state_d = ST_CSUM;
                    else if (len_n > LEN_W'(MAX_WORDS))
                        state_d = ST_ERR;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ byte_data;
                    if (word_full)
                        state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_d  = addr_q + 1'b1;
                left_d  = left_q - 1'b1;
                state_d = (left_q == LEN_W'(1)) ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
                if (accept)
                    state_d = (byte_data == csum_q) ? ST_DONE : ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered copies of the next-state decode.
        byte_ready_d = takes_byte(state_d);
        busy_d       = in_session(state_d);
        mem_we_d     = (state_d == ST_WRITE);
        done_d       = (state_d == ST_DONE);
        err_d        = (state_d == ST_ERR);
        cpu_rst_d    = (state_d != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            len_lo_q     <= '0;
            left_q       <= '0;
            csum_q       <= '0;
            addr_q       <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cpu_rst_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            left_q       <= left_d;
            csum_q       <= csum_d;
            addr_q       <= addr_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cpu_rst_q    <= cpu_rst_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cpu_rst    = cpu_rst_q;

endmodule

// File: tb/tb_xprog_loader.sv
// Scoreboard bench for xprog_loader: a frame-level model predicts
// the memory writes and final status of each randomized session.
module tb_xprog_loader;
    import xprog_loader_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start;
    logic                       byte_valid;
    logic [7:0]                 byte_data;
    logic                       byte_ready;
    logic                       mem_we;
    logic [PROG_ROM_ADDR_W-1:0] mem_addr;
    logic [INSTR_W-1:0]         mem_wdata;
    logic                       busy;
    logic                       done;
    logic                       err;
    logic                       cpu_rst;

    xprog_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_rst    (cpu_rst)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next predicted write.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_we actual addr=%0d data=%h expected no write",
                         mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("we_addr", 32'(mem_addr), e.addr);
                chk("we_data", mem_wdata, e.data);
                chk("we_ready_low", 32'(byte_ready), 32'd0);
            end
        end
    end

    // Frame-level reference: parse length, slice words, XOR all bytes.
    task automatic model(input logic [7:0] f[$], output int consumed,
                         output bit ok);
        int n;
        logic [7:0] x;
        n = int'(f[0]) + 256 * int'(f[1]);
        if (n > MAX_WORDS) begin
            consumed = 2;
            ok = 1'b0;
            return;
        end
        for (int w = 0; w < n; w++)
            sb.push_back('{w, {f[5+4*w], f[4+4*w], f[3+4*w], f[2+4*w]}});
        x = 8'h00;
        for (int i = 0; i < 2 + 4 * n; i++)
            x = x ^ f[i];
        consumed = 3 + 4 * n;
        ok = (f[2+4*n] == x);
    endtask

    task automatic make_frame(input int n, input bit good,
                              output logic [7:0] f[$]);
        logic [7:0] x;
        f = {};
        f.push_back(8'(n));
        f.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++)
            f.push_back(8'($urandom_range(0, 255)));
        x = 8'h00;
        foreach (f[i]) x = x ^ f[i];
        f.push_back(good ? x : (x ^ 8'h01));
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("start_done_clr", 32'(done), 32'd0);
        chk("start_err_clr", 32'(err), 32'd0);
    endtask

    task automatic send(input logic [7:0] f[$], input int cnt,
                        input int maxgap, input int start_at);
        bit acc;
        for (int i = 0; i < cnt; i++) begin
            repeat ($urandom_range(0, maxgap)) begin
                @(posedge clk);
                #1;
            end
            byte_valid = 1'b1;
            byte_data  = f[i];
            if (i == start_at) start = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                @(negedge clk);
                acc = byte_ready;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            byte_valid = 1'b0;
            if (!acc) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=no_accept expected=byte %0d taken", i);
                return;
            end
        end
    endtask

    task automatic finish_check(input bit ok);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            seen = done || err;
        end
        chk("end_reached", 32'(seen), 32'd1);
        chk("end_done", 32'(done), 32'(ok));
        chk("end_err", 32'(err), 32'(!ok));
        chk("end_cpu_rst", 32'(cpu_rst), 32'(!ok));
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_ready", 32'(byte_ready), 32'd0);
        chk("end_writes_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic run(input logic [7:0] f[$], input int maxgap,
                       input int start_at);
        int cons;
        bit ok;
        model(f, cons, ok);
        do_start();
        send(f, cons, maxgap, start_at);
        finish_check(ok);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] f[$];
        logic [7:0] fixed[$];
        int cons;
        bit ok;

        rst = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        @(posedge clk);
        #1;

        fixed = {8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};
        run(fixed, 0, -1);

        f = fixed;
        f[10] = 8'h00;
        run(f, 0, -1);
        f[10] = 8'h01;
        run(f, 0, -1);

        f = {8'h00, 8'h00, 8'h00};
        run(f, 0, -1);

        // Oversized length: ERR right after LEN_HI, nothing written.
        f = {8'h01, 8'h01, 8'h55, 8'h66};
        model(f, cons, ok);
        do_start();
        send(f, cons, 0, -1);
        chk("oversize_err_now", 32'(err), 32'd1);
        chk("oversize_ready", 32'(byte_ready), 32'd0);
        finish_check(ok);

        make_frame(MAX_WORDS, 1'b1, f);
        run(f, 0, -1);

        run(fixed, 5, 5);
        for (int r = 0; r < 8; r++) begin
            make_frame($urandom_range(0, 5), $urandom_range(0, 3) != 0, f);
            run(f, 5, (f.size() > 4) ? int'($urandom_range(2, f.size() - 2)) : -1);
        end

        // Reset after six data bytes: word 0 written, word 1 abandoned.
        model(fixed, cons, ok);
        do_start();
        send(fixed, 8, 2, -1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_pending_writes", 32'(sb.size()), 32'd1);
        sb.delete();
        repeat (3) @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(byte_ready), 32'd0);
        chk("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_addr", 32'(mem_addr), 32'd0);
        @(posedge clk);
        #1;
        run(fixed, 0, -1);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
